// File: rtl/mt_pkg.sv
// Shared definitions for the multithreaded register-file writeback queue.
// Holds the default configuration and the queued writeback entry layout.
package mt_pkg;

  localparam int NUM_THREADS = 8;
  localparam int DATA_WIDTH  = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int TID_W       = $clog2(NUM_THREADS);

  // One queued writeback: owning thread, destination register, value.
  typedef struct packed {
    logic [TID_W-1:0]      tid;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/mt_wb_fifo.sv
// Writeback FIFO for one thread-parity bank.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   push, push_*        - enqueue {tid, rd, data}; ignored when full
//   pop                 - dequeue head; ignored when empty
//   head_*              - current head entry (valid when !empty)
//   count, full, empty  - occupancy 0..DEPTH
//   ent_valid/tid/rd    - per-slot view used by the read-hazard compare
module mt_wb_fifo
  import mt_pkg::*;
#(
  parameter int  TID_W  = 3,
  parameter int  DATA_W = 32,
  parameter int  DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push,
  input  logic [TID_W-1:0]                     push_tid,
  input  logic [REG_ADDR_W-1:0]                push_rd,
  input  logic [DATA_W-1:0]                    push_data,
  input  logic                                 pop,
  output logic [TID_W-1:0]                     head_tid,
  output logic [REG_ADDR_W-1:0]                head_rd,
  output logic [DATA_W-1:0]                    head_data,
  output logic [CNT_W-1:0]                     count,
  output logic                                 full,
  output logic                                 empty,
  output logic [DEPTH-1:0]                     ent_valid,
  output logic [DEPTH-1:0][TID_W-1:0]          ent_tid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     ent_rd
);

  logic [DEPTH-1:0][TID_W-1:0]      tid_q;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_q;
  logic [DEPTH-1:0][DATA_W-1:0]     data_q;
  logic [DEPTH-1:0]                 vld_q;
  logic [PTR_W-1:0]                 wr_ptr, rd_ptr;
  logic                             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_tid  = tid_q[rd_ptr];
  assign head_rd   = rd_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  assign ent_valid = vld_q;
  assign ent_tid   = tid_q;
  assign ent_rd    = rd_q;

  // Payload needs no reset: vld_q/count gate every use of it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      tid_q[wr_ptr]  <= push_tid;
      rd_q[wr_ptr]   <= push_rd;
      data_q[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  // Push and pop never target the same slot: push needs !full, pop needs
  // !empty, and wr_ptr==rd_ptr only at those extremes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld_q  <= '0;
    end else begin
      if (do_push) begin
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mt_rf_wb_queue.sv
// Writeback queue in front of a banked multithreaded register file.
// Results are split by thread parity into two FIFOs; each cycle at most one
// head is written back, preferring the bank the read port is not using.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   in_valid/in_ready/in_*      - writeback result handshake {tid, rd, data}
//   rd_valid, rd_tid, rd_a1/a2  - register file read port this cycle
//   write_enable, tid_write,
//   a3, wd3                     - register file write port (pops the head)
//   hazard1, hazard2            - read source still has a queued write
//   even_count, odd_count       - FIFO occupancies
module mt_rf_wb_queue
  import mt_pkg::*;
#(
  parameter int  NUM_THREADS  = mt_pkg::NUM_THREADS,
  parameter int  DATA_WIDTH   = mt_pkg::DATA_WIDTH,
  parameter int  DEPTH        = 4,
  parameter int  BITS_THREADS = $clog2(NUM_THREADS),
  localparam int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BITS_THREADS-1:0] in_tid,
  input  logic [REG_ADDR_W-1:0]   in_rd,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    rd_valid,
  input  logic [BITS_THREADS-1:0] rd_tid,
  input  logic [REG_ADDR_W-1:0]   rd_a1,
  input  logic [REG_ADDR_W-1:0]   rd_a2,
  output logic                    write_enable,
  output logic [BITS_THREADS-1:0] tid_write,
  output logic [REG_ADDR_W-1:0]   a3,
  output logic [DATA_WIDTH-1:0]   wd3,
  output logic                    hazard1,
  output logic                    hazard2,
  output logic [CNT_W-1:0]        even_count,
  output logic [CNT_W-1:0]        odd_count
);

  // Index 0 = even-thread bank, 1 = odd-thread bank.
  logic [1:0]                               push, pop, full, empty;
  logic [1:0][BITS_THREADS-1:0]             head_tid;
  logic [1:0][REG_ADDR_W-1:0]               head_rd;
  logic [1:0][DATA_WIDTH-1:0]               head_data;
  logic [1:0][CNT_W-1:0]                    count;
  logic [1:0][DEPTH-1:0]                    ent_valid;
  logic [1:0][DEPTH-1:0][BITS_THREADS-1:0]  ent_tid;
  logic [1:0][DEPTH-1:0][REG_ADDR_W-1:0]    ent_rd;

  for (genvar p = 0; p < 2; p++) begin : g_fifo
    mt_wb_fifo #(
      .TID_W (BITS_THREADS),
      .DATA_W(DATA_WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[p]),
      .push_tid (in_tid),
      .push_rd  (in_rd),
      .push_data(in_data),
      .pop      (pop[p]),
      .head_tid (head_tid[p]),
      .head_rd  (head_rd[p]),
      .head_data(head_data[p]),
      .count    (count[p]),
      .full     (full[p]),
      .empty    (empty[p]),
      .ent_valid(ent_valid[p]),
      .ent_tid  (ent_tid[p]),
      .ent_rd   (ent_rd[p])
    );
  end

  assign even_count = count[0];
  assign odd_count  = count[1];

  logic in_par, rd_par, in_keep;
  assign in_par  = in_tid[0];
  assign rd_par  = rd_tid[0];
  assign in_keep = (in_rd != '0);

  // Writes to r0 are swallowed, so they never wait on a full bank. Ready
  // looks only at full (not at a same-cycle pop) to keep it off the
  // drain path.
  assign in_ready = !in_keep || !full[in_par];

  always_comb begin
    push = '0;
    if (in_valid && in_keep && !full[in_par]) push[in_par] = 1'b1;
  end

  // Drain selection: the read port occupies bank rd_par, so only the other
  // bank may write while a read is in flight.
  logic [1:0] elig, cand;
  logic       prio, tie, sel;

  assign elig[0] = !rd_valid || rd_par;
  assign elig[1] = !rd_valid || !rd_par;
  assign cand    = elig & ~empty & {2{!rst}};
  assign tie     = &cand;
  assign sel     = tie ? prio : cand[1];

  always_comb begin
    pop          = '0;
    write_enable = |cand;
    tid_write    = '0;
    a3           = '0;
    wd3          = '0;
    if (write_enable) begin
      pop[sel]  = 1'b1;
      tid_write = head_tid[sel];
      a3        = head_rd[sel];
      wd3       = head_data[sel];
    end
  end

  // Round-robin only matters when both banks compete.
  always_ff @(posedge clk) begin
    if (rst)      prio <= 1'b0;
    else if (tie) prio <= ~prio;
  end

  // Hazard: any queued (including being-popped) write of the reading thread
  // to a source register. Only the reading thread's own bank can hold it.
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[rd_par][i] && ent_tid[rd_par][i] == rd_tid) begin
        if (ent_rd[rd_par][i] == rd_a1) hazard1 = 1'b1;
        if (ent_rd[rd_par][i] == rd_a2) hazard2 = 1'b1;
      end
    end
    hazard1 = hazard1 && rd_valid && (rd_a1 != '0) && !rst;
    hazard2 = hazard2 && rd_valid && (rd_a2 != '0) && !rst;
  end

endmodule

// File: tb/tb_mt_rf_wb_queue.sv
// Self-checking bench for mt_rf_wb_queue: directed scenarios followed by
// randomized traffic, every cycle compared against a queue-based model.
module tb_mt_rf_wb_queue;
  import mt_pkg::*;

  localparam int DEPTH = 4;
  localparam int TW    = 3;
  localparam int CW    = 3;

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [TW-1:0] in_tid;
  logic [4:0]    in_rd;
  logic [31:0]   in_data;
  logic          rd_valid;
  logic [TW-1:0] rd_tid;
  logic [4:0]    rd_a1, rd_a2;
  logic          write_enable;
  logic [TW-1:0] tid_write;
  logic [4:0]    a3;
  logic [31:0]   wd3;
  logic          hazard1, hazard2;
  logic [CW-1:0] even_count, odd_count;

  mt_rf_wb_queue #(.NUM_THREADS(8), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_tid(in_tid),
    .in_rd(in_rd), .in_data(in_data),
    .rd_valid(rd_valid), .rd_tid(rd_tid), .rd_a1(rd_a1), .rd_a2(rd_a2),
    .write_enable(write_enable), .tid_write(tid_write), .a3(a3), .wd3(wd3),
    .hazard1(hazard1), .hazard2(hazard2),
    .even_count(even_count), .odd_count(odd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one queue per thread parity, plus tie-break turn.
  wb_entry_t qe[$];
  wb_entry_t qo[$];
  bit        turn_odd;

  function automatic int qsize(input bit p);
    return p ? qo.size() : qe.size();
  endfunction

  function automatic bit qhit(input bit p, input logic [TW-1:0] t, input logic [4:0] r);
    wb_entry_t e;
    int n = qsize(p);
    for (int i = 0; i < n; i++) begin
      e = p ? qo[i] : qe[i];
      if (e.tid == t && e.rd == r) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Inputs are already applied; compare at negedge, then advance the model
  // to what the coming posedge should do.
  task automatic step();
    bit ready, ce, co, sel, we, h1, h2;
    wb_entry_t h, n;
    @(negedge clk);
    ready = (in_rd == 0) || (qsize(in_tid[0]) < DEPTH);
    ce    = !rst && (!rd_valid || rd_tid[0])  && qe.size() > 0;
    co    = !rst && (!rd_valid || !rd_tid[0]) && qo.size() > 0;
    sel   = (ce && co) ? turn_odd : co;
    we    = ce || co;
    h     = '0;
    if (we) h = sel ? qo[0] : qe[0];
    h1 = !rst && rd_valid && rd_a1 != 0 && qhit(rd_tid[0], rd_tid, rd_a1);
    h2 = !rst && rd_valid && rd_a2 != 0 && qhit(rd_tid[0], rd_tid, rd_a2);
    chk("in_ready",     in_ready,     ready);
    chk("write_enable", write_enable, we);
    chk("tid_write",    tid_write,    h.tid);
    chk("a3",           a3,           h.rd);
    chk("wd3",          wd3,          h.data);
    chk("hazard1",      hazard1,      h1);
    chk("hazard2",      hazard2,      h2);
    chk("even_count",   even_count,   qe.size());
    chk("odd_count",    odd_count,    qo.size());
    if (rst) begin
      qe.delete();
      qo.delete();
      turn_odd = 1'b0;
    end else begin
      if (we) begin
        if (sel) void'(qo.pop_front());
        else     void'(qe.pop_front());
        if (ce && co) turn_odd = !turn_odd;
      end
      if (in_valid && ready && in_rd != 0) begin
        n.tid = in_tid; n.rd = in_rd; n.data = in_data;
        if (in_tid[0]) qo.push_back(n);
        else           qe.push_back(n);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_in(input int t, input int r, input logic [31:0] d);
    in_valid = 1'b1;
    in_tid   = TW'(t);
    in_rd    = 5'(r);
    in_data  = d;
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    rd_valid = 1'b0;
    repeat (n) step();
  endtask

  logic p0;

  initial begin
    turn_odd = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_tid = '0; in_rd = '0; in_data = '0;
    rd_valid = 1'b0; rd_tid = '0; rd_a1 = '0; rd_a2 = '0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    #1 chk("post_reset_ready", in_ready, 1'b1);
    step();

    // Single push drains the next cycle
    push_in(2, 5, 32'hA5A5_A5A5);
    step();
    in_valid = 1'b0;
    #1;
    chk("r19_we",  write_enable, 1'b1);
    chk("r19_tid", tid_write, 3'd2);
    chk("r19_a3",  a3, 5'd5);
    chk("r19_wd3", wd3, 32'hA5A5_A5A5);
    step();
    chk("r19_cnt", even_count, 3'd0);

    // Read on the even bank blocks even drain
    rd_valid = 1'b1; rd_tid = 3'd0;
    push_in(4, 7, 32'h1234_5678);
    step();
    in_valid = 1'b0;
    repeat (3) begin
      #1;
      chk("r20_blocked_we",  write_enable, 1'b0);
      chk("r20_blocked_cnt", even_count, 3'd1);
      step();
    end
    rd_tid = 3'd1;
    #1;
    chk("r20_we", write_enable, 1'b1);
    chk("r20_a3", a3, 5'd7);
    step();

    // Fill the odd bank while it is blocked
    rd_valid = 1'b1; rd_tid = 3'd3;
    for (int i = 0; i < 4; i++) begin
      push_in(2 * i + 1, i + 1, $urandom);
      step();
    end
    push_in(5, 6, 32'hDEAD_0001);
    #1 chk("r21_full_ready", in_ready, 1'b0);
    step();
    push_in(6, 8, 32'hDEAD_0002);
    #1 chk("r21_even_ready", in_ready, 1'b1);
    step();
    push_in(5, 0, 32'hDEAD_0003);
    #1 chk("r21_r0_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    #1 chk("r21_odd_cnt", odd_count, 3'd4);
    step();
    drain(8);

    // Hazard detection
    rd_valid = 1'b1; rd_tid = 3'd3;
    push_in(3, 9, 32'h0000_0099);
    step();
    in_valid = 1'b0; rd_a1 = 5'd9; rd_a2 = 5'd0;
    #1;
    chk("r22_h1", hazard1, 1'b1);
    chk("r22_h2", hazard2, 1'b0);
    step();
    rd_tid = 3'd1;
    #1 chk("r22_h1_other", hazard1, 1'b0);
    step();
    rd_tid = 3'd3; rd_a1 = 5'd0; rd_a2 = 5'd9;
    #1 chk("r22_h2_swap", hazard2, 1'b1);
    step();
    drain(3);

    // Both banks busy: alternation, then reset mid-drain
    rd_valid = 1'b1; rd_tid = 3'd0;
    for (int i = 0; i < 3; i++) begin
      push_in(2 * i, i + 10, $urandom);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      push_in(2 * i + 1, i + 20, $urandom);
      step();
    end
    in_valid = 1'b0; rd_valid = 1'b0;
    #1 p0 = tid_write[0];
    step();
    chk("r23_alt", tid_write[0], !p0);
    step();
    rst = 1'b1;
    #1 chk("r23_rst_we", write_enable, 1'b0);
    step();
    rst = 1'b0;
    chk("r23_rst_even", even_count, 3'd0);
    chk("r23_rst_odd",  odd_count,  3'd0);
    step();
    step();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_tid   = TW'($urandom);
      in_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      in_data  = $urandom;
      rd_valid = ($urandom_range(0, 3) != 0);
      rd_tid   = TW'($urandom);
      rd_a1    = 5'($urandom_range(0, 7));
      rd_a2    = 5'($urandom_range(0, 7));
      step();
    end
    rst = 1'b0;
    drain(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
